opr_seq_dec: RTL and testbench
==============================

# opr_seq_dec

Receive-side decoder and checker for the staggered stage-enable pulses opr_1..opr_5 and opr_finished produced by the operation controller. It sits beside the 5-stage series datapath:
- recovers the pipeline phase from the thermometer-coded enables;
- emits a retire pulse and running count for every instruction that reaches stage 5;
- flags protocol violations;
- signals end of a 1024-line run to the top level.

## Interface
- N_STAGES, 5, number of stage enables (thermometer length)
- LAST_CNT, 1023, controller count value at which opr_finished is asserted
- CNT_W, 11, width of internal cycle tracker
- RET_W, 8, width of retire_cnt (204 retirements per run fits)

- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- valid  in  1  same start strobe fed to the controller
- opr_1..opr_5  in  1 each  stage enables from controller
- opr_finished  in  1  end-of-run flag from controller
- phase  out  3  registered decoded phase 0..4
- busy  out  1  high while in RUN
- retire  out  1  one-cycle pulse: instruction completed stage 5
- retire_cnt  out  RET_W  retirements in current/last run
- run_done  out  1  one-cycle pulse after final run cycle
- err_code  out  1  sticky: illegal enable pattern
- err_seq  out  1  sticky: legal pattern, wrong phase
- err_fin  out  1  sticky: opr_finished at wrong cycle or missing

## Operation
- Legal codes (opr_1..opr_5): 10000=ph0, 11000=ph1, 11100=ph2, 11110=ph3, 11111=ph4. Anything else, including opr_1=0, is illegal.
- Phase of an illegal code decodes as 0.
- States: IDLE, RUN. Encoded in a 1-bit enum.
- IDLE:
  - Expected code is ph0; mismatch sets err_code or err_seq.
  - opr_finished=1 sets err_fin.
  - valid=1 at a clock edge:
    - go to RUN;
    - tracker<=1, expected phase<=1;
    - clear retire_cnt and all three error flags (the flags' next value is the current cycle's check, not an OR with the old value).
- RUN, each cycle:
  - Compare the code to the expected phase (tracker mod 5, kept as a mod-5 counter, no divider).
  - Illegal code sets err_code; legal but wrong code sets err_seq.
  - Mismatch between opr_finished and (tracker==LAST_CNT) sets err_fin.
  - Expected phase advances on every cycle regardless of mismatch; no resynchronisation.
  - valid is ignored.
- Retire: a legal ph4 code seen in RUN sets retire=1 and retire_cnt+1 at the next edge. retire_cnt saturates at all-ones.
- End of run: in RUN with tracker==LAST_CNT, the next edge sets state<=IDLE and run_done=1 for one cycle. A nominal run ends with retire_cnt=204.
- Values are held after the run: retire_cnt and the error flags hold until the next start or reset.
- busy = (state==RUN), registered.

## Timing
- Reset value of every output is 0, including phase=0.
- Internal state on reset: IDLE, tracker=0, expected phase=0.
- Decode latency:
  - phase and retire are registered, one cycle after the enables;
  - retire_cnt updates on the same edge as retire;
  - error flags are set one edge after the offending cycle.
- Start alignment: valid sampled at edge E. Controller shows ph1 in cycle E+1; tracker=1 is expected in that same cycle.
- run_done:
  - asserts in the cycle after the LAST_CNT cycle, i.e. valid edge + 1024 cycles;
  - busy falls on the same edge.
- valid high during the run_done cycle: a new run starts at the following edge. retire_cnt shows 204 during run_done and clears at that edge.
- Reset mid-run: all outputs go to 0 immediately; the block returns to IDLE.
- Phase wrap: LAST_CNT mod 5 = 3, so the final cycle shows ph3 and the following cycle ph0. No ph4 follows, so retire does not assert after the last ph3.

## Structure
- Package opr_pkg holds:
  - N_STAGES=5, LAST_CNT=1023, RETIRES_PER_RUN=204;
  - typedef enum logic {IDLE, RUN} opr_dec_state_t;
  - typedef logic [2:0] opr_phase_t.
- Sub-module opr_therm_dec (combinational): input code[4:0]; outputs phase (opr_phase_t) and legal.
- Top-level opr_seq_dec holds the FSM, tracker, mod-5 expected counter, retire counter and error flags.

## Test plan
- Reset, idle code 10000 held for 20 cycles -> all outputs 0, no error flags.
- Drive with a golden controller model, one valid pulse -> phase sequences 1,2,3,4,0,…; 204 retire pulses; run_done at valid edge + 1024; retire_cnt=204; no errors.
- valid asserted in the run_done cycle -> second run starts cleanly; retire_cnt clears to 0 on that edge and ends at 204 again.
- Force code 10100 on cycle 37 of a run -> err_code=1 from cycle 38, held until next start; count still 204 minus any corrupted ph4.
- Skip a phase (ph2->ph4) once -> err_seq=1. Assert opr_finished at tracker=500 -> err_fin=1. Suppress opr_finished at 1023 -> err_fin=1.
- Deassert rstb at tracker=600 -> all outputs 0 asynchronously; next valid gives a full 204-retire run.

Source files
------------

// File: rtl/opr_pkg.sv
// Shared types and constants for the operation-sequence decoder.
// Covers the thermometer stage-enable code, the FSM state and the phase type.
package opr_pkg;

    localparam int unsigned N_STAGES        = 5;
    localparam int unsigned LAST_CNT        = 1023;
    localparam int unsigned RETIRES_PER_RUN = 204;

    typedef enum logic {IDLE, RUN} opr_dec_state_t;

    typedef logic [2:0] opr_phase_t;

    // Mod-5 increment; avoids a divider on the tracker.
    function automatic opr_phase_t next_phase(input opr_phase_t p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/opr_therm_dec.sv
// Combinational decoder from the 5-bit thermometer stage-enable code to a phase.
// Bit 4 is opr_1. Illegal codes report phase 0 with legal low.
module opr_therm_dec
    import opr_pkg::*;
(
    input  logic [4:0] code,
    output opr_phase_t phase,
    output logic       legal
);

    always_comb begin
        phase = 3'd0;
        legal = 1'b1;
        unique case (code)
            5'b10000: phase = 3'd0;
            5'b11000: phase = 3'd1;
            5'b11100: phase = 3'd2;
            5'b11110: phase = 3'd3;
            5'b11111: phase = 3'd4;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/opr_seq_dec.sv
// Receive-side decoder/checker for the controller's staggered stage enables.
// Tracks the run phase, counts retirements and flags protocol violations.
module opr_seq_dec #(
    parameter int unsigned N_STAGES = opr_pkg::N_STAGES,
    parameter int unsigned LAST_CNT = opr_pkg::LAST_CNT,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned RET_W    = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             valid,
    input  logic             opr_1,
    input  logic             opr_2,
    input  logic             opr_3,
    input  logic             opr_4,
    input  logic             opr_5,
    input  logic             opr_finished,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             retire,
    output logic [RET_W-1:0] retire_cnt,
    output logic             run_done,
    output logic             err_code,
    output logic             err_seq,
    output logic             err_fin
);

    import opr_pkg::*;

    logic [N_STAGES-1:0] code;
    opr_phase_t          dec_phase;
    logic                dec_legal;

    opr_dec_state_t   state_q, state_d;
    logic [CNT_W-1:0] trk_q, trk_d;
    opr_phase_t       exp_q, exp_d;
    opr_phase_t       phase_q;
    logic             retire_q, retire_d;
    logic [RET_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             e_code_q, e_code_d;
    logic             e_seq_q, e_seq_d;
    logic             e_fin_q, e_fin_d;

    logic start;
    logic last;
    logic code_bad;
    logic seq_bad;
    logic fin_bad;

    assign code = {opr_1, opr_2, opr_3, opr_4, opr_5};

    opr_therm_dec u_therm_dec (
        .code  (code),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    assign start    = (state_q == IDLE) && valid;
    assign last     = (state_q == RUN) && (trk_q == CNT_W'(LAST_CNT));
    // exp_q is held at 0 while idle, so the same compare covers both states.
    assign code_bad = !dec_legal;
    assign seq_bad  = dec_legal && (dec_phase != exp_q);
    assign fin_bad  = (state_q == RUN) ? (opr_finished != last) : opr_finished;

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy     = (state_q == RUN);
        retire_d = (state_q == RUN) && dec_legal && (dec_phase == 3'd4);
        done_d   = last;
    end

    // Tracker, expected phase, retire counter and error flags.
    always_comb begin
        trk_d = trk_q;
        exp_d = exp_q;
        if (start) begin
            trk_d = CNT_W'(1);
            exp_d = 3'd1;
        end else if (state_q == RUN) begin
            if (last) begin
                trk_d = '0;
                exp_d = 3'd0;
            end else begin
                trk_d = trk_q + CNT_W'(1);
                exp_d = next_phase(exp_q);
            end
        end

        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (retire_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + RET_W'(1);
        end

        // A start replaces the old flags with this cycle's result.
        if (start) begin
            e_code_d = code_bad;
            e_seq_d  = seq_bad;
            e_fin_d  = fin_bad;
        end else begin
            e_code_d = e_code_q | code_bad;
            e_seq_d  = e_seq_q  | seq_bad;
            e_fin_d  = e_fin_q  | fin_bad;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            trk_q    <= '0;
            exp_q    <= 3'd0;
            phase_q  <= 3'd0;
            retire_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            e_code_q <= 1'b0;
            e_seq_q  <= 1'b0;
            e_fin_q  <= 1'b0;
        end else begin
            trk_q    <= trk_d;
            exp_q    <= exp_d;
            phase_q  <= dec_phase;
            retire_q <= retire_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            e_code_q <= e_code_d;
            e_seq_q  <= e_seq_d;
            e_fin_q  <= e_fin_d;
        end
    end

    assign phase      = phase_q;
    assign retire     = retire_q;
    assign retire_cnt = cnt_q;
    assign run_done   = done_q;
    assign err_code   = e_code_q;
    assign err_seq    = e_seq_q;
    assign err_fin    = e_fin_q;

endmodule

// File: tb/tb_opr_seq_dec.sv
// Directed bench for opr_seq_dec, driving a golden controller model.
// Covers nominal runs, chained runs, corrupted codes, finish errors and mid-run reset.
module tb_opr_seq_dec;

    logic       clk = 1'b0;
    logic       rstb;
    logic       valid;
    logic       opr_1, opr_2, opr_3, opr_4, opr_5;
    logic       opr_finished;
    logic [2:0] phase;
    logic       busy;
    logic       retire;
    logic [7:0] retire_cnt;
    logic       run_done;
    logic       err_code;
    logic       err_seq;
    logic       err_fin;

    int checks = 0;
    int errors = 0;

    opr_seq_dec u_dut (
        .clk          (clk),
        .rstb         (rstb),
        .valid        (valid),
        .opr_1        (opr_1),
        .opr_2        (opr_2),
        .opr_3        (opr_3),
        .opr_4        (opr_4),
        .opr_5        (opr_5),
        .opr_finished (opr_finished),
        .phase        (phase),
        .busy         (busy),
        .retire       (retire),
        .retire_cnt   (retire_cnt),
        .run_done     (run_done),
        .err_code     (err_code),
        .err_seq      (err_seq),
        .err_fin      (err_fin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] therm(input int p);
        case (p)
            0:       return 5'b10000;
            1:       return 5'b11000;
            2:       return 5'b11100;
            3:       return 5'b11110;
            default: return 5'b11111;
        endcase
    endfunction

    // Returns the phase of a legal code, -1 for an illegal one.
    function automatic int dec(input logic [4:0] c);
        case (c)
            5'b10000: return 0;
            5'b11000: return 1;
            5'b11100: return 2;
            5'b11110: return 3;
            5'b11111: return 4;
            default:  return -1;
        endcase
    endfunction

    task automatic drive(input logic [4:0] c, input logic fin);
        {opr_1, opr_2, opr_3, opr_4, opr_5} = c;
        opr_finished = fin;
    endtask

    task automatic idle(input int n);
        drive(5'b10000, 1'b0);
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {16'd0, phase, busy, retire, retire_cnt, run_done, err_code, err_seq, err_fin},
            32'd0);
    endtask

    // Caller sets valid=1 with the idle code in place; this consumes the start edge.
    task automatic run_one(input int bad_t, input logic [4:0] bad_c, input int fin_x,
                           input bit fin_sup, input int rst_t, input int exp_rets);
        int         rets     = 0;
        int         expc     = 0;
        int         ph_bad   = 0;
        int         ret_bad  = 0;
        int         cnt_bad  = 0;
        int         busy_bad = 0;
        int         done_bad = 0;
        int         p;
        int         pe;
        bit         aborted  = 1'b0;
        logic [4:0] c;

        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt", 32'(retire_cnt), 32'd0);
        chk("start_flags", 32'({err_code, err_seq, err_fin}), 32'd0);

        for (int t = 1; t <= 1023; t++) begin
            c = (t == bad_t) ? bad_c : therm(t % 5);
            drive(c, ((t == 1023) && !fin_sup) || (t == fin_x));
            if (t == rst_t) begin
                rstb = 1'b0;
                #1;
                chk_all_zero("async_reset");
                @(posedge clk);
                #1;
                chk_all_zero("reset_hold");
                rstb    = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            p  = dec(c);
            pe = (p < 0) ? 0 : p;
            if (phase !== pe[2:0]) ph_bad++;
            if (retire !== (p == 4)) ret_bad++;
            if (retire === 1'b1) rets++;
            if ((p == 4) && (expc < 255)) expc++;
            if (retire_cnt !== expc[7:0]) cnt_bad++;
            if (busy !== (t != 1023)) busy_bad++;
            if (run_done !== (t == 1023)) done_bad++;
        end
        drive(5'b10000, 1'b0);

        if (!aborted) begin
            chk("phase_seq", 32'(ph_bad), 32'd0);
            chk("retire_pulse", 32'(ret_bad), 32'd0);
            chk("retire_cnt_track", 32'(cnt_bad), 32'd0);
            chk("busy_track", 32'(busy_bad), 32'd0);
            chk("run_done_timing", 32'(done_bad), 32'd0);
            chk("retire_total", 32'(rets), 32'(exp_rets));
            chk("end_cnt", 32'(retire_cnt), 32'(exp_rets));
        end
    endtask

    initial begin
        rstb  = 1'b0;
        valid = 1'b0;
        drive(5'b10000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstb = 1'b1;
        idle(20);
        chk_all_zero("idle20");

        valid = 1'b1;
        run_one(0, 5'b00000, 0, 1'b0, 0, 204);
        chk("run1_flags", 32'({err_code, err_seq, err_fin}), 32'd0);

        // Chained start in the run_done cycle.
        valid = 1'b1;
        run_one(0, 5'b00000, 0, 1'b0, 0, 204);
        chk("run2_flags", 32'({err_code, err_seq, err_fin}), 32'd0);
        idle(1);
        chk("done_single", 32'(run_done), 32'd0);
        chk("cnt_hold", 32'(retire_cnt), 32'd204);
        chk("busy_idle", 32'(busy), 32'd0);

        valid = 1'b1;
        run_one(37, 5'b10100, 0, 1'b0, 0, 204);
        chk("code_flags", 32'({err_code, err_seq, err_fin}), 32'b100);
        idle(5);
        chk("code_held", 32'({err_code, err_seq, err_fin}), 32'b100);

        // ph2 -> ph4 skip: the stray ph4 is legal and retires.
        valid = 1'b1;
        run_one(8, 5'b11111, 0, 1'b0, 0, 205);
        chk("seq_flags", 32'({err_code, err_seq, err_fin}), 32'b010);

        valid = 1'b1;
        run_one(0, 5'b00000, 500, 1'b0, 0, 204);
        chk("fin_early_flags", 32'({err_code, err_seq, err_fin}), 32'b001);

        valid = 1'b1;
        run_one(0, 5'b00000, 0, 1'b1, 0, 204);
        chk("fin_missing_flags", 32'({err_code, err_seq, err_fin}), 32'b001);

        valid = 1'b1;
        run_one(0, 5'b00000, 0, 1'b0, 600, 0);
        idle(3);
        chk_all_zero("post_reset");
        valid = 1'b1;
        run_one(0, 5'b00000, 0, 1'b0, 0, 204);
        chk("post_reset_flags", 32'({err_code, err_seq, err_fin}), 32'd0);

        idle(1);
        drive(5'b11000, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_seq", 32'({err_code, err_seq, err_fin}), 32'b010);
        drive(5'b10000, 1'b1);
        @(posedge clk);
        #1;
        chk("idle_fin", 32'({err_code, err_seq, err_fin}), 32'b011);
        drive(5'b01000, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_code", 32'({err_code, err_seq, err_fin}), 32'b111);
        chk("idle_phase_illegal", 32'(phase), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
